// File: rtl/video_axis_pkg.sv
// Shared definitions for the video AXI4-Stream blocks.
//   RGB_WIDTH      : bits per RGB888 pixel
//   merge_state_t  : frame_pair_merger alignment state
//   pixel_pair_t   : layout of a joined pixel pair, previous frame in the upper half
package video_axis_pkg;

    localparam int RGB_WIDTH = 24;

    typedef enum logic {
        SYNC = 1'b0,
        RUN  = 1'b1
    } merge_state_t;

    typedef struct packed {
        logic [RGB_WIDTH-1:0] prev;
        logic [RGB_WIDTH-1:0] cur;
    } pixel_pair_t;

endpackage

// File: rtl/axis_skid_buffer.sv
// Two-entry AXI4-Stream skid buffer with fully registered outputs.
// The output register presents the head beat; a second register catches the
// beat accepted while the output is stalled. s_tready is a flop (skid slot
// empty), so it never depends combinationally on m_tready.
//   clk, srst          : clock, synchronous active-high reset
//   s_tdata/tvalid     : upstream beat (only asserted when s_tready is high)
//   s_tready           : registered, high while at least one slot is free
//   m_tdata/tvalid     : registered downstream beat
//   m_tready           : downstream accept
module axis_skid_buffer #(
    parameter int WIDTH = 50
) (
    input  logic             clk,
    input  logic             srst,
    input  logic [WIDTH-1:0] s_tdata,
    input  logic             s_tvalid,
    output logic             s_tready,
    output logic [WIDTH-1:0] m_tdata,
    output logic             m_tvalid,
    input  logic             m_tready
);

    logic [WIDTH-1:0] out_data_reg;
    logic             out_valid_reg;
    logic [WIDTH-1:0] skid_data_reg;
    logic             skid_valid_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            out_data_reg   <= '0;
            out_valid_reg  <= 1'b0;
            skid_data_reg  <= '0;
            skid_valid_reg <= 1'b0;
        end else if (!out_valid_reg || m_tready) begin
            // Output slot frees this cycle: drain the skid entry first to keep order.
            // When the skid entry is occupied s_tready is low, so nothing is pushed.
            if (skid_valid_reg) begin
                out_data_reg   <= skid_data_reg;
                out_valid_reg  <= 1'b1;
                skid_valid_reg <= 1'b0;
            end else begin
                out_valid_reg <= s_tvalid;
                if (s_tvalid) begin
                    out_data_reg <= s_tdata;
                end
            end
        end else if (s_tvalid && !skid_valid_reg) begin
            skid_data_reg  <= s_tdata;
            skid_valid_reg <= 1'b1;
        end
    end

    assign s_tready = !skid_valid_reg;
    assign m_tdata  = out_data_reg;
    assign m_tvalid = out_valid_reg;

endmodule

// File: rtl/frame_pair_merger.sv
// Joins the current-frame and previous-frame AXI4-Stream video streams into a
// single pixel-pair stream {prev, cur}, aligned on start-of-frame (tuser).
//   aclk, areset               : clock, synchronous active-high reset
//   cur_*  (tdata/tvalid/tuser/tlast/tready)  : live video input
//   prev_* (tdata/tvalid/tuser/tlast/tready)  : frame-buffer read-back input
//   pair_* (tdata/tvalid/tuser/tlast/tready)  : joined output, registered
//   stat_clear                 : pulse clearing resync_count and tlast_mismatch
//   resync_count               : saturating count of RUN -> SYNC transitions
//   tlast_mismatch             : sticky, a joined beat had differing tlast
module frame_pair_merger
    import video_axis_pkg::*;
#(
    parameter int TDATA_WIDTH = RGB_WIDTH,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                     aclk,
    input  logic                     areset,
    input  logic [TDATA_WIDTH-1:0]   cur_tdata,
    input  logic                     cur_tvalid,
    input  logic                     cur_tuser,
    input  logic                     cur_tlast,
    output logic                     cur_tready,
    input  logic [TDATA_WIDTH-1:0]   prev_tdata,
    input  logic                     prev_tvalid,
    input  logic                     prev_tuser,
    input  logic                     prev_tlast,
    output logic                     prev_tready,
    output logic [2*TDATA_WIDTH-1:0] pair_tdata,
    output logic                     pair_tvalid,
    output logic                     pair_tuser,
    output logic                     pair_tlast,
    input  logic                     pair_tready,
    input  logic                     stat_clear,
    output logic [CNT_WIDTH-1:0]     resync_count,
    output logic                     tlast_mismatch
);

    // Skid entry: {tuser, tlast, prev pixel, cur pixel}
    localparam int SKID_WIDTH = 2 * TDATA_WIDTH + 2;

    merge_state_t           state_reg, state_next;
    logic [CNT_WIDTH-1:0]   resync_count_reg;
    logic                   tlast_mismatch_reg;

    logic                   skid_in_ready;
    logic                   push;
    logic                   resync_event;
    logic                   both_valid;
    logic [SKID_WIDTH-1:0]  skid_in_data;
    logic [SKID_WIDTH-1:0]  skid_out_data;

    assign both_valid = cur_tvalid && prev_tvalid;

    always_comb begin
        state_next   = state_reg;
        cur_tready   = 1'b0;
        prev_tready  = 1'b0;
        push         = 1'b0;
        resync_event = 1'b0;
        if (!areset) begin
            case (state_reg)
                SYNC: begin
                    // Mid-frame beats are flushed; a start-of-frame head waits for its partner.
                    if (cur_tvalid && !cur_tuser) begin
                        cur_tready = 1'b1;
                    end
                    if (prev_tvalid && !prev_tuser) begin
                        prev_tready = 1'b1;
                    end
                    if (both_valid && cur_tuser && prev_tuser && skid_in_ready) begin
                        cur_tready  = 1'b1;
                        prev_tready = 1'b1;
                        push        = 1'b1;
                        state_next  = RUN;
                    end
                end
                RUN: begin
                    if (both_valid) begin
                        if (cur_tuser == prev_tuser) begin
                            if (skid_in_ready) begin
                                cur_tready  = 1'b1;
                                prev_tready = 1'b1;
                                push        = 1'b1;
                            end
                        end else begin
                            // One stream hit a new frame early: realign without popping either head.
                            state_next   = SYNC;
                            resync_event = 1'b1;
                        end
                    end
                end
                default: state_next = SYNC;
            endcase
        end
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            state_reg          <= SYNC;
            resync_count_reg   <= '0;
            tlast_mismatch_reg <= 1'b0;
        end else begin
            state_reg <= state_next;

            // A new event outranks a simultaneous clear.
            if (resync_event) begin
                if (stat_clear) begin
                    resync_count_reg <= CNT_WIDTH'(1);
                end else if (resync_count_reg != {CNT_WIDTH{1'b1}}) begin
                    resync_count_reg <= resync_count_reg + CNT_WIDTH'(1);
                end
            end else if (stat_clear) begin
                resync_count_reg <= '0;
            end

            if (push && (cur_tlast != prev_tlast)) begin
                tlast_mismatch_reg <= 1'b1;
            end else if (stat_clear) begin
                tlast_mismatch_reg <= 1'b0;
            end
        end
    end

    assign skid_in_data = {cur_tuser, cur_tlast, prev_tdata, cur_tdata};

    axis_skid_buffer #(
        .WIDTH (SKID_WIDTH)
    ) u_skid (
        .clk      (aclk),
        .srst     (areset),
        .s_tdata  (skid_in_data),
        .s_tvalid (push),
        .s_tready (skid_in_ready),
        .m_tdata  (skid_out_data),
        .m_tvalid (pair_tvalid),
        .m_tready (pair_tready)
    );

    assign pair_tuser     = skid_out_data[SKID_WIDTH-1];
    assign pair_tlast     = skid_out_data[SKID_WIDTH-2];
    assign pair_tdata     = skid_out_data[2*TDATA_WIDTH-1:0];
    assign resync_count   = resync_count_reg;
    assign tlast_mismatch = tlast_mismatch_reg;

endmodule
